tocador_nota: RTL and testbench
===============================

TOCADOR_NOTA -- requirements
Module: tocador_nota

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; forces the reset state of REQ-020.
REQ-004 start  input  1  request to play one word; sampled only in IDLE.
REQ-005 tipo  input  2  word class to play: 01 adj, 10 comp, 11 adv, 00 invalid; captured when start is accepted.
REQ-006 ready  input  1  downstream receiver accepts the current note at this edge.
REQ-007 ok  output  1  note valid; nota and tom are stable while ok=1.
REQ-008 nota  output  3  note code: 000 nota_x (terminator), 001 do, 010 re, 011 mi, 100 fa, 101 sol, 110 la, 111 si.
REQ-009 tom  output  1  octave flag of the current note: 0 low, 1 high.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse after the terminator is accepted.
REQ-012 err  output  1  one-cycle pulse when start is accepted with tipo=00.

Function
REQ-013 FSM states SHALL be IDLE, SEND, DONE and ERR, and all outputs SHALL be registered.
REQ-014 In IDLE with start=1, tipo SHALL be latched, the index SHALL be cleared to 0, and the next state SHALL be SEND if tipo!=00, else ERR.
REQ-015 ok SHALL rise in the cycle after the start edge, giving one cycle of latency.
REQ-016 In SEND, ok=1 and nota/tom SHALL equal ROM[tipo][idx].
- On an edge with ready=1 and idx<5: idx SHALL increment.
- On an edge with ready=1 and idx=5: the next state SHALL be DONE.
- With ready=0: outputs SHALL hold unchanged, with no limit on stall length.
REQ-017 The ROM SHALL hold these (nota, tom) entries for idx 0..5:
- adj: do0 re0 mi0 fa0 la0 x0
- comp: do0 mi0 sol0 la0 do1 x0
- adv: re0 fa0 sol0 la0 si0 x0
REQ-018 DONE and ERR SHALL each last exactly one cycle, asserting done or err respectively, with ok=0, then return to IDLE.
REQ-019 start SHALL be ignored in every state other than IDLE, and tipo changes after acceptance SHALL have no effect.
- A start held high in the DONE or ERR cycle SHALL be accepted in the following IDLE cycle.
- With ready=1 throughout, the sequence SHALL be: start edge, 6 transfer cycles, 1 done cycle; the next start is accepted 8 cycles after the first.

Reset
REQ-020 Asserting reset SHALL immediately, without waiting for a clock edge, force state=IDLE, idx=0, latched tipo=00, ok=0, nota=000, tom=0, busy=0, done=0 and err=0.
REQ-021 A reset during SEND SHALL abandon the word with no done or err pulse.
- The first start after reset release SHALL be accepted at the first rising edge with reset low.

Configuration
REQ-022 When the macro TOCADOR_NOTA_DISPLAY_EN is defined, the block SHALL add output display[6:0] (segments gfedcba, active-high).
- display SHALL show the nota digit 0-7 while ok=1, and segment g only (dash) otherwise.
- display SHALL be registered, SHALL update on the same edge as nota, and SHALL reset to 0000000.
REQ-023 When TOCADOR_NOTA_DISPLAY_EN is not defined, the display port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-024 With tipo=01 and start pulsed while ready=1, the bench SHALL see nota 001,010,011,100,110,000 with tom all 0 on consecutive cycles, then done=1 for one cycle, then busy=0.
REQ-025 With tipo=10 and ready toggling 1,0 each cycle, the bench SHALL see each note held for 2 cycles, the do entry at idx 4 with tom=1, and done after the terminator is accepted.
REQ-026 With tipo=00 and start, the bench SHALL see err=1 for one cycle, ok never asserted, and busy high for 1 cycle only.
REQ-027 When reset is asserted mid-sequence (tipo=11, idx=3), the bench SHALL see ok, busy and nota go to 0 before the next edge; no done pulse; and a new start after release plays from re (idx 0).
REQ-028 When start=1 and tipo changes from 11 to 01 during SEND, the bench SHALL see the adv sequence play unchanged; with start still high, the adj sequence SHALL begin in the IDLE cycle after done.
REQ-029 With TOCADOR_NOTA_DISPLAY_EN defined and tipo=11, the bench SHALL see display show 2,4,5,6,7,0 during the transfers and a dash in idle cycles.

Source files
------------

// File: rtl/tocador_nota.sv
// Plays one word as a sequence of (nota, tom) notes from a fixed ROM over a ready/ok handshake.
// Optional 7-segment output is enabled by defining TOCADOR_NOTA_DISPLAY_EN.
module tocador_nota (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] tipo,
  input  logic       ready,
  output logic       ok,
  output logic [2:0] nota,
  output logic       tom,
  output logic       busy,
  output logic       done,
  output logic       err
`ifdef TOCADOR_NOTA_DISPLAY_EN
  ,
  output logic [6:0] display
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t     state, state_nx;
  logic [2:0] idx, idx_nx;
  logic [1:0] tipo_q, tipo_nx;

  logic       ok_nx, tom_nx, busy_nx, done_nx, err_nx;
  logic [2:0] nota_nx;

  // Entries are {nota, tom}; index 5 is always the terminator.
  function automatic logic [3:0] rom(input logic [1:0] t, input logic [2:0] i);
    logic [3:0] e;
    e = 4'b0000;
    case (t)
      2'b01: case (i)
        3'd0: e = {3'b001, 1'b0};
        3'd1: e = {3'b010, 1'b0};
        3'd2: e = {3'b011, 1'b0};
        3'd3: e = {3'b100, 1'b0};
        3'd4: e = {3'b110, 1'b0};
        default: e = 4'b0000;
      endcase
      2'b10: case (i)
        3'd0: e = {3'b001, 1'b0};
        3'd1: e = {3'b011, 1'b0};
        3'd2: e = {3'b101, 1'b0};
        3'd3: e = {3'b110, 1'b0};
        3'd4: e = {3'b001, 1'b1};
        default: e = 4'b0000;
      endcase
      2'b11: case (i)
        3'd0: e = {3'b010, 1'b0};
        3'd1: e = {3'b100, 1'b0};
        3'd2: e = {3'b101, 1'b0};
        3'd3: e = {3'b110, 1'b0};
        3'd4: e = {3'b111, 1'b0};
        default: e = 4'b0000;
      endcase
      default: e = 4'b0000;
    endcase
    return e;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= 3'd0;
      tipo_q <= 2'b00;
      ok     <= 1'b0;
      nota   <= 3'b000;
      tom    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nx;
      idx    <= idx_nx;
      tipo_q <= tipo_nx;
      ok     <= ok_nx;
      nota   <= nota_nx;
      tom    <= tom_nx;
      busy   <= busy_nx;
      done   <= done_nx;
      err    <= err_nx;
    end
  end

  // Outputs are derived from the next state so they appear registered on the same edge.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    tipo_nx  = tipo_q;
    case (state)
      IDLE: begin
        if (start) begin
          tipo_nx  = tipo;
          idx_nx   = 3'd0;
          state_nx = (tipo != 2'b00) ? SEND : ERR;
        end
      end
      SEND: begin
        if (ready) begin
          if (idx == 3'd5) state_nx = DONE;
          else             idx_nx   = idx + 3'd1;
        end
      end
      DONE:    state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    ok_nx   = (state_nx == SEND);
    busy_nx = (state_nx != IDLE);
    done_nx = (state_nx == DONE);
    err_nx  = (state_nx == ERR);
    if (ok_nx) {nota_nx, tom_nx} = rom(tipo_nx, idx_nx);
    else       {nota_nx, tom_nx} = 4'b0000;
  end

`ifdef TOCADOR_NOTA_DISPLAY_EN
  logic [6:0] display_nx;

  always_comb begin
    display_nx = 7'b1000000;
    if (ok_nx) begin
      case (nota_nx)
        3'd0: display_nx = 7'b0111111;
        3'd1: display_nx = 7'b0000110;
        3'd2: display_nx = 7'b1011011;
        3'd3: display_nx = 7'b1001111;
        3'd4: display_nx = 7'b1100110;
        3'd5: display_nx = 7'b1101101;
        3'd6: display_nx = 7'b1111101;
        3'd7: display_nx = 7'b0000111;
        default: display_nx = 7'b1000000;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) display <= 7'b0000000;
    else       display <= display_nx;
  end
`endif

endmodule

// File: tb/tb_tocador_nota.sv
// Directed self-checking bench for tocador_nota; exercises the display when TOCADOR_NOTA_DISPLAY_EN is defined.
module tb_tocador_nota;

  logic       clk = 1'b0;
  logic       reset, start, ready, ok, tom, busy, done, err;
  logic [1:0] tipo;
  logic [2:0] nota;
`ifdef TOCADOR_NOTA_DISPLAY_EN
  logic [6:0] display;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Observation word: {ok, nota, tom, busy, done, err}
  logic [7:0] obs;
  assign obs = {ok, nota, tom, busy, done, err};

  // Expected {nota, tom} per word class, index 0..5.
  logic [3:0] exp_adj  [0:5] = '{4'b0010, 4'b0100, 4'b0110, 4'b1000, 4'b1100, 4'b0000};
  logic [3:0] exp_comp [0:5] = '{4'b0010, 4'b0110, 4'b1010, 4'b1100, 4'b0011, 4'b0000};
  logic [3:0] exp_adv  [0:5] = '{4'b0100, 4'b1000, 4'b1010, 4'b1100, 4'b1110, 4'b0000};

  tocador_nota dut (
    .clk(clk), .reset(reset), .start(start), .tipo(tipo), .ready(ready),
    .ok(ok), .nota(nota), .tom(tom), .busy(busy), .done(done), .err(err)
`ifdef TOCADOR_NOTA_DISPLAY_EN
    , .display(display)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; tipo = 2'b00; ready = 1'b0;
    #1;
    vectors++;
    if (obs !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_state: got %b want %b", obs, 8'h00);
    end
`ifdef TOCADOR_NOTA_DISPLAY_EN
    vectors++;
    if (display !== 7'b0000000) begin
      miscompares++;
      $display("FAIL reset_display: got %b want 0000000", display);
    end
`endif
    tick; tick;
    reset = 1'b0;
    tick;
    vectors++;
    if (obs !== 8'h00) begin
      miscompares++;
      $display("FAIL idle_after_reset: got %b want %b", obs, 8'h00);
    end
  endtask

  task automatic test_adj;
    tipo = 2'b01; start = 1'b1; ready = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (obs !== {1'b1, exp_adj[i], 3'b100}) begin
        miscompares++;
        $display("FAIL adj_note%0d: got %b want %b", i, obs, {1'b1, exp_adj[i], 3'b100});
      end
      tick;
    end
    vectors++;
    if (obs !== 8'b0_000_0_110) begin
      miscompares++;
      $display("FAIL adj_done: got %b want %b", obs, 8'b0_000_0_110);
    end
    tick;
    vectors++;
    if (obs !== 8'h00) begin
      miscompares++;
      $display("FAIL adj_idle: got %b want %b", obs, 8'h00);
    end
  endtask

  task automatic test_comp_stall;
    tipo = 2'b10; start = 1'b1; ready = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      for (int ph = 0; ph < 2; ph++) begin
        ready = (ph == 1);
        vectors++;
        if (obs !== {1'b1, exp_comp[i], 3'b100}) begin
          miscompares++;
          $display("FAIL comp_note%0d_ph%0d: got %b want %b", i, ph, obs, {1'b1, exp_comp[i], 3'b100});
        end
        tick;
      end
    end
    ready = 1'b0;
    vectors++;
    if (obs !== 8'b0_000_0_110) begin
      miscompares++;
      $display("FAIL comp_done: got %b want %b", obs, 8'b0_000_0_110);
    end
    tick;
    vectors++;
    if (obs !== 8'h00) begin
      miscompares++;
      $display("FAIL comp_idle: got %b want %b", obs, 8'h00);
    end
  endtask

  task automatic test_invalid;
    tipo = 2'b00; start = 1'b1; ready = 1'b1;
    tick;
    start = 1'b0;
    vectors++;
    if (obs !== 8'b0_000_0_101) begin
      miscompares++;
      $display("FAIL invalid_err: got %b want %b", obs, 8'b0_000_0_101);
    end
    tick;
    vectors++;
    if (obs !== 8'h00) begin
      miscompares++;
      $display("FAIL invalid_idle: got %b want %b", obs, 8'h00);
    end
    tick;
    vectors++;
    if (obs !== 8'h00) begin
      miscompares++;
      $display("FAIL invalid_stays_idle: got %b want %b", obs, 8'h00);
    end
  endtask

  task automatic test_reset_mid;
    tipo = 2'b11; start = 1'b1; ready = 1'b1;
    tick;
    start = 1'b0;
    tick; tick; tick;
    vectors++;
    if (obs !== {1'b1, exp_adv[3], 3'b100}) begin
      miscompares++;
      $display("FAIL mid_idx3: got %b want %b", obs, {1'b1, exp_adv[3], 3'b100});
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (obs !== 8'h00) begin
      miscompares++;
      $display("FAIL mid_async_reset: got %b want %b", obs, 8'h00);
    end
    tick; tick;
    vectors++;
    if (obs !== 8'h00) begin
      miscompares++;
      $display("FAIL mid_no_done: got %b want %b", obs, 8'h00);
    end
    reset = 1'b0; start = 1'b1; tipo = 2'b11;
    tick;
    start = 1'b0;
    vectors++;
    if (obs !== {1'b1, exp_adv[0], 3'b100}) begin
      miscompares++;
      $display("FAIL mid_restart: got %b want %b", obs, {1'b1, exp_adv[0], 3'b100});
    end
    repeat (7) tick;
    vectors++;
    if (obs !== 8'h00) begin
      miscompares++;
      $display("FAIL mid_finish_idle: got %b want %b", obs, 8'h00);
    end
  endtask

  task automatic test_back_to_back;
    tipo = 2'b11; start = 1'b1; ready = 1'b1;
    tick;
    tipo = 2'b01;
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (obs !== {1'b1, exp_adv[i], 3'b100}) begin
        miscompares++;
        $display("FAIL b2b_adv%0d: got %b want %b", i, obs, {1'b1, exp_adv[i], 3'b100});
      end
      tick;
    end
    vectors++;
    if (obs !== 8'b0_000_0_110) begin
      miscompares++;
      $display("FAIL b2b_done: got %b want %b", obs, 8'b0_000_0_110);
    end
    tick;
    vectors++;
    if (obs !== 8'h00) begin
      miscompares++;
      $display("FAIL b2b_idle: got %b want %b", obs, 8'h00);
    end
    tick;
    start = 1'b0;
    vectors++;
    if (obs !== {1'b1, exp_adj[0], 3'b100}) begin
      miscompares++;
      $display("FAIL b2b_adj_start: got %b want %b", obs, {1'b1, exp_adj[0], 3'b100});
    end
    tick;
    vectors++;
    if (obs !== {1'b1, exp_adj[1], 3'b100}) begin
      miscompares++;
      $display("FAIL b2b_adj_next: got %b want %b", obs, {1'b1, exp_adj[1], 3'b100});
    end
    repeat (6) tick;
    vectors++;
    if (obs !== 8'h00) begin
      miscompares++;
      $display("FAIL b2b_final_idle: got %b want %b", obs, 8'h00);
    end
  endtask

`ifdef TOCADOR_NOTA_DISPLAY_EN
  task automatic test_display;
    logic [6:0] exp_seg [0:5];
    exp_seg = '{7'b1011011, 7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111, 7'b0111111};
    vectors++;
    if (display !== 7'b1000000) begin
      miscompares++;
      $display("FAIL disp_idle: got %b want 1000000", display);
    end
    tipo = 2'b11; start = 1'b1; ready = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (display !== exp_seg[i]) begin
        miscompares++;
        $display("FAIL disp_note%0d: got %b want %b", i, display, exp_seg[i]);
      end
      tick;
    end
    vectors++;
    if (display !== 7'b1000000) begin
      miscompares++;
      $display("FAIL disp_done_dash: got %b want 1000000", display);
    end
    tick;
    vectors++;
    if (display !== 7'b1000000) begin
      miscompares++;
      $display("FAIL disp_idle_after: got %b want 1000000", display);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_adj;
    test_comp_stall;
    test_invalid;
    test_reset_mid;
    test_back_to_back;
`ifdef TOCADOR_NOTA_DISPLAY_EN
    test_display;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
